oled_spi_byte_tx: RTL
=====================

# oled_spi_byte_tx

Responder end of the `sendData`/`sendDataValid`/`sendDone` byte handshake used by the OLED string streamer. It accepts one byte plus a data/command flag per four-phase handshake, shifts the byte out MSB-first on an SSD1306-compatible SPI link (mode 3), and drives the D/C# line. It sits between the byte producers (string streamer, init sequencer) and the OLED pins.

## Interface

- `CLK_DIV`, default 5: system clocks per SPI half-period. The default gives 10 MHz SPI from 100 MHz. Legal range is ≥1.
- `clock`  in  1  100 MHz system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sendData`  in  8  byte to transmit. Sampled only at acceptance.
- `sendDc`  in  1  1 = data, 0 = command. Sampled at acceptance.
- `sendDataValid`  in  1  request from the producer. Level-held until `sendDone` is seen.
- `sendDone`  out  1  byte fully shifted. Held high until `sendDataValid` drops.
- `busy`  out  1  high in SHIFT or DONE.
- `oled_spi_clk`  out  1  SPI clock. Idles high.
- `oled_spi_data`  out  1  MOSI.
- `oled_dc_n`  out  1  D/C# pin. Holds the value latched at the last acceptance.

## Operation

- State machine has three states: IDLE, SHIFT and DONE.
- IDLE → SHIFT when `sendDataValid`=1 and `sendDone`=0. On that edge:
  - `sendData` loads into an 8-bit shift register.
  - `oled_dc_n` <= `sendDc`.
  - `oled_spi_data` <= `sendData[7]`.
  - Divider counter and half-period counter clear to 0.
- SHIFT:
  - Divider counts 0..`CLK_DIV`-1. At terminal count, `oled_spi_clk` toggles and the half-period counter increments (0..15).
  - Falling toggles (even half-period count k=0,2,…,14) drive `oled_spi_data` <= bit 7−k/2, changing data while the clock is low.
  - Rising toggles are the slave's sample points.
- SHIFT → DONE on the 16th toggle (8th rising edge). `sendDone` <= 1 on the same edge, and `oled_spi_clk` ends high.
- DONE → IDLE on the first cycle with `sendDataValid`=0. `sendDone` <= 0 on that edge.
- Changes on `sendData` or `sendDc` after acceptance are ignored.
- `sendDataValid` dropping during SHIFT does not abort the byte. On entering DONE the valid is already low, so `sendDone` is high for exactly one cycle.
- `sendDataValid` held high through DONE keeps `sendDone` high indefinitely, and no second byte is accepted.
- Reset (any time, including mid-byte) forces the following asynchronously, and the partial byte is abandoned:
  - state IDLE
  - `oled_spi_clk`=1
  - `oled_spi_data`=0
  - `oled_dc_n`=1
  - `sendDone`=0
  - `busy`=0
  - counters 0
- Counter widths: divider is $clog2(`CLK_DIV`) bits, minimum 1. Half-period counter is 4 bits.

## Timing

- Acceptance is the edge ending cycle 0, where IDLE sees valid=1 and done=0.
- First falling edge of `oled_spi_clk` occurs at the end of cycle `CLK_DIV`. The 16th toggle occurs at the end of cycle 16·`CLK_DIV`.
- `sendDone` first reads 1 in cycle 16·`CLK_DIV`+1 (81 at the default).
- `sendDone` falls one cycle after `sendDataValid` is first seen low.
- The earliest next acceptance is the cycle after `sendDone` reads 0, as gated by the producer's `!sendDone` check.
- All outputs are registered, with no combinational path from inputs to outputs.
- Each half-period is exactly `CLK_DIV` cycles. With `CLK_DIV`=1, `oled_spi_clk` toggles every cycle.

## Structure

- Shared package `oled_pkg` holds:
  - state encoding localparams IDLE=0, SHIFT=1, DONE=2 (2-bit)
  - `OLED_SPI_CPOL`=1
  - `OLED_DC_CMD`=0 and `OLED_DC_DATA`=1
- One natural sub-module, `spi_half_tick`. It is the `CLK_DIV` divider emitting a one-cycle tick at terminal count, with counting enabled only in SHIFT. The top-level FSM toggles the clock and shifts data on the tick.

## Test plan

- **Byte 0xA5 with `sendDc`=1, `CLK_DIV`=5:**
  - MOSI sampled on the 8 rising edges reads 1,0,1,0,0,1,0,1.
  - `oled_dc_n`=1.
  - `sendDone` rises in cycle 81.
  - Clock ends high.
- **Four-phase handshake with the string streamer:**
  - Drive 64 bytes "Hello world" padded with 0x00, valid dropped one cycle after `sendDone`.
  - All 64 bytes are captured in order.
  - `sendDone` falls one cycle after valid drops each time.
- **Valid dropped at cycle 20 of a byte 0x3C:**
  - The full 0x3C still shifts out.
  - `sendDone` is high for exactly one cycle (cycle 81).
  - A new valid=1 at cycle 30 is not accepted before IDLE.
- **`sendData` changed 0x3C→0xFF at cycle 10:**
  - Transmitted byte is 0x3C.
  - `oled_dc_n` keeps the value latched at acceptance.
- **`reset_n` low at cycle 40 of a byte:**
  - Outputs go to clk=1, data=0, dc_n=1, done=0, busy=0 in the same cycle, without a clock edge.
  - After release, byte 0x81 transmits cleanly.
- **`CLK_DIV`=1:**
  - `oled_spi_clk` toggles every cycle.
  - `sendDone` reads 1 in cycle 17 for byte 0xF0, which reads 1,1,1,1,0,0,0,0.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared constants and types for the OLED SPI byte transmitter.
package oled_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = IDLE,
        StShift = SHIFT,
        StDone  = DONE
    } tx_state_e;

    localparam logic OLED_SPI_CPOL = 1'b1;
    localparam logic OLED_DC_CMD   = 1'b0;
    localparam logic OLED_DC_DATA  = 1'b1;

    // Divider counter width: $clog2 of the divisor, never below one bit.
    function automatic int unsigned div_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/oled_spi_byte_tx_if.sv
// Four-phase byte handshake between a byte producer and the SPI transmitter.
interface oled_spi_byte_tx_if;

    logic [7:0] sendData;
    logic       sendDc;
    logic       sendDataValid;
    logic       sendDone;
    logic       busy;

    modport master (
        output sendData,
        output sendDc,
        output sendDataValid,
        input  sendDone,
        input  busy
    );

    modport slave (
        input  sendData,
        input  sendDc,
        input  sendDataValid,
        output sendDone,
        output busy
    );

endinterface

// File: rtl/spi_half_tick.sv
// SPI half-period divider: one-cycle tick every CLK_DIV enabled cycles.
module spi_half_tick
    import oled_pkg::*;
#(
    parameter int unsigned CLK_DIV = 5
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned DivW = div_width(CLK_DIV);
    localparam logic [DivW-1:0] Term = DivW'(CLK_DIV - 1);

    logic [DivW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == Term);

    // Counter sits at zero whenever disabled, so every byte starts a fresh half-period.
    always_comb begin
        cnt_d = '0;
        if (en_i && !tick_o) begin
            cnt_d = cnt_q + DivW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/oled_spi_byte_tx.sv
// Accepts one byte per four-phase handshake and shifts it out MSB-first on SPI mode 3.
module oled_spi_byte_tx
    import oled_pkg::*;
#(
    parameter int unsigned CLK_DIV = 5
) (
    input  logic                clock,
    input  logic                reset_n,
    oled_spi_byte_tx_if.slave   bus,
    output logic                oled_spi_clk,
    output logic                oled_spi_data,
    output logic                oled_dc_n
);

    tx_state_e  state_q;
    logic [7:0] shift_q;
    logic [3:0] half_q;
    logic       spi_clk_q;
    logic       spi_data_q;
    logic       dc_q;
    logic       done_q;
    logic       busy_q;
    logic       tick;

    spi_half_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_half_tick (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .en_i   (state_q == StShift),
        .tick_o (tick)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            half_q     <= '0;
            spi_clk_q  <= OLED_SPI_CPOL;
            spi_data_q <= 1'b0;
            dc_q       <= OLED_DC_DATA;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.sendDataValid && !done_q) begin
                        state_q    <= StShift;
                        shift_q    <= bus.sendData;
                        dc_q       <= bus.sendDc;
                        spi_data_q <= bus.sendData[7];
                        half_q     <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                StShift: begin
                    if (tick) begin
                        spi_clk_q <= ~spi_clk_q;
                        half_q    <= half_q + 4'd1;
                        // Even counts are falling edges: present the next bit while SCK is low.
                        if (!half_q[0]) begin
                            spi_data_q <= shift_q[7];
                        end else begin
                            shift_q <= {shift_q[6:0], 1'b0};
                            if (half_q == 4'd15) begin
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end
                StDone: begin
                    if (!bus.sendDataValid) begin
                        state_q <= StIdle;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.sendDone  = done_q;
    assign bus.busy      = busy_q;
    assign oled_spi_clk  = spi_clk_q;
    assign oled_spi_data = spi_data_q;
    assign oled_dc_n     = dc_q;

endmodule
